udp_frame_builder: RTL and testbench



---
 rtl/udp_tx_pkg.sv | 39 +++
 rtl/ip_hdr_csum.sv | 25 ++
 rtl/udp_frame_builder.sv | 255 +++++++++++++++++++++++++
 tb/tb_udp_frame_builder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared types and constants for the UDP transmit frame builder.
//   state_t    - frame builder FSM states
//   ETH/IP/UDP - fixed header field values and header byte counts
//   keep_mask  - byte-lane mask keeping the leading nbytes of a 64-bit word
package udp_tx_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CSUM,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_HDR4,
        S_PAY,
        S_TAIL,
        S_DROP
    } state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;

    localparam int HDR_BYTES     = 42;
    localparam int UDP_HDR_BYTES = 8;
    localparam int IP_HDR_BYTES  = 20;

    // Byte 0 sits on [63:56]; counts of 8 or more keep the whole word.
    function automatic logic [63:0] keep_mask(input logic [15:0] nbytes);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (nbytes > 16'(i)) m[63-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// ip_hdr_csum: combinational IPv4 header checksum.
//   hdr_words - nine 16-bit header words (checksum field excluded)
//   csum      - ones-complement of the folded ones-complement sum
module ip_hdr_csum (
    input  logic [8:0][15:0] hdr_words,
    output logic [15:0]      csum
);

    logic [19:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + {4'h0, hdr_words[i]};
        end
        // Nine words fit in 20 bits; the second fold absorbs the carry the
        // first fold can produce, and cannot itself overflow.
        fold1 = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
        fold2 = fold1[15:0] + {15'h0, fold1[16]};
        csum  = ~fold2;
    end

endmodule

// File: rtl/udp_frame_builder.sv
// udp_frame_builder: wraps a 64-bit UDP payload stream into an
// Ethernet/IPv4/UDP frame (42-byte header, payload shifted by 2 bytes).
// Byte 0 of every word is on [63:56].
//   clk, reset_n (synchronous, active-low)
//   in_*         - payload stream (valid/ready, sop/eop), payload_len at sop
//   cfg_*        - MAC/IP/port/id fields, latched at sop
//   out_*        - frame stream (valid/ready, sop/eop, out_empty on eop word)
//   err_len      - pulse: payload_len is 0 or above MAX_PAYLOAD
//   err_eop      - pulse: in_eop disagrees with payload_len
// Build option: define IPID_AUTOINC_EN to take ip_id from an internal counter
// that advances after each emitted frame instead of cfg_ip_id.
//
// state | meaning
// IDLE  | waiting for sop (taken only when the output register can load)
// CSUM  | checksum registered; loads W0
// HDR0  | W0 on output; loads W1
// HDR1  | W1 on output; loads W2
// HDR2  | W2 on output; loads W3
// HDR3  | W3 on output; loads W4
// HDR4  | W4 on output; consumes first payload word
// PAY   | payload on output; consumes next payload word
// TAIL  | loads final word holding the last 2 payload bytes
// DROP  | discards input until in_eop
module udp_frame_builder
    import udp_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 1472,
    parameter logic [7:0] IP_TTL      = 8'h40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [15:0] payload_len,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    input  logic [15:0] cfg_ip_id,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_empty,
    output logic        err_len,
    output logic        err_eop
);

    state_t      state, state_nxt;
    logic [15:0] len_q, rem_q, ip_id_q, csum_q, csum_c, ip_id_src;
    logic [47:0] dst_mac_q, src_mac_q;
    logic [31:0] src_ip_q, dst_ip_q;
    logic [15:0] src_port_q, dst_port_q;
    logic [15:0] prev_q;
    logic        fill_q, late_q;

    logic        load, last_in, have_word, in_ready_c;
    logic        ld, w_sop, w_eop, latch_cfg, len_bad, eop_err;
    logic        step_pay, set_fill, set_late;
    logic [63:0] w_data, pay_masked;
    logic [2:0]  w_empty, len_empty;
    logic [15:0] ip_len, udp_len;

`ifdef IPID_AUTOINC_EN
    logic [15:0] ip_ctr;
    logic        eop_hs;
    assign eop_hs = out_valid & out_ready & out_eop;
    always_ff @(posedge clk) begin
        if (!reset_n)    ip_ctr <= '0;
        else if (eop_hs) ip_ctr <= ip_ctr + 16'd1;
    end
    // A frame finishing on this very edge has already used the old value.
    assign ip_id_src = ip_ctr + {15'h0, eop_hs};
`else
    assign ip_id_src = cfg_ip_id;
`endif

    assign load       = !out_valid || out_ready;
    assign ip_len     = len_q + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
    assign udp_len    = len_q + 16'(UDP_HDR_BYTES);
    assign len_empty  = 3'd6 - len_q[2:0];
    assign last_in    = rem_q <= 16'd8;
    assign have_word  = fill_q || in_valid;
    // After an early eop the frame is padded with zero words, not input.
    assign pay_masked = (fill_q ? 64'h0 : in_data) & keep_mask(rem_q);
    assign in_ready   = reset_n & in_ready_c;

    ip_hdr_csum u_csum (
        .hdr_words({{IP_VER_IHL, 8'h00}, ip_len, ip_id_q, IP_FLAGS_DF,
                    {IP_TTL, IP_PROTO_UDP}, src_ip_q[31:16], src_ip_q[15:0],
                    dst_ip_q[31:16], dst_ip_q[15:0]}),
        .csum     (csum_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        ld         = 1'b0;
        w_data     = '0;
        w_sop      = 1'b0;
        w_eop      = 1'b0;
        w_empty    = '0;
        latch_cfg  = 1'b0;
        len_bad    = 1'b0;
        eop_err    = 1'b0;
        step_pay   = 1'b0;
        set_fill   = 1'b0;
        set_late   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load && in_valid && in_sop) begin
                    latch_cfg = 1'b1;
                    if (payload_len == 16'd0 || payload_len > 16'(MAX_PAYLOAD)) begin
                        len_bad   = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: if (load) begin
                ld        = 1'b1;
                w_data    = {dst_mac_q, src_mac_q[47:32]};
                w_sop     = 1'b1;
                state_nxt = S_HDR0;
            end
            S_HDR0: if (load) begin
                ld        = 1'b1;
                w_data    = {src_mac_q[31:0], ETH_TYPE_IPV4, IP_VER_IHL, 8'h00};
                state_nxt = S_HDR1;
            end
            S_HDR1: if (load) begin
                ld        = 1'b1;
                w_data    = {ip_len, ip_id_q, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP};
                state_nxt = S_HDR2;
            end
            S_HDR2: if (load) begin
                ld        = 1'b1;
                w_data    = {csum_q, src_ip_q, dst_ip_q[31:16]};
                state_nxt = S_HDR3;
            end
            S_HDR3: if (load) begin
                ld        = 1'b1;
                w_data    = {dst_ip_q[15:0], src_port_q, dst_port_q, udp_len};
                state_nxt = S_HDR4;
            end
            S_HDR4, S_PAY: begin
                in_ready_c = load && !fill_q;
                if (load && have_word) begin
                    ld       = 1'b1;
                    step_pay = 1'b1;
                    // First payload word carries the zero UDP checksum.
                    w_data   = {(state == S_HDR4) ? 16'h0000 : prev_q, pay_masked[63:16]};
                    if (!fill_q) begin
                        if (in_eop && !last_in) begin
                            eop_err  = 1'b1;
                            set_fill = 1'b1;
                        end else if (!in_eop && last_in) begin
                            eop_err  = 1'b1;
                            set_late = 1'b1;
                        end
                    end
                    if (!last_in) begin
                        state_nxt = S_PAY;
                    end else if (rem_q <= 16'd6) begin
                        w_eop     = 1'b1;
                        w_empty   = len_empty;
                        state_nxt = (late_q || set_late) ? S_DROP : S_IDLE;
                    end else begin
                        state_nxt = S_TAIL;
                    end
                end
            end
            S_TAIL: if (load) begin
                ld        = 1'b1;
                w_data    = {prev_q, 48'h0};
                w_eop     = 1'b1;
                w_empty   = len_empty;
                state_nxt = late_q ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                in_ready_c = 1'b1;
                if (in_valid && in_eop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_empty  <= '0;
            err_len    <= 1'b0;
            err_eop    <= 1'b0;
            len_q      <= '0;
            rem_q      <= '0;
            ip_id_q    <= '0;
            csum_q     <= '0;
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            prev_q     <= '0;
            fill_q     <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            err_len <= len_bad;
            err_eop <= eop_err;
            if (load) begin
                out_valid <= ld;
                out_data  <= w_data;
                out_sop   <= w_sop;
                out_eop   <= w_eop;
                out_empty <= w_empty;
            end
            if (latch_cfg) begin
                len_q      <= payload_len;
                rem_q      <= payload_len;
                ip_id_q    <= ip_id_src;
                dst_mac_q  <= cfg_dst_mac;
                src_mac_q  <= cfg_src_mac;
                src_ip_q   <= cfg_src_ip;
                dst_ip_q   <= cfg_dst_ip;
                src_port_q <= cfg_src_port;
                dst_port_q <= cfg_dst_port;
                fill_q     <= 1'b0;
                late_q     <= 1'b0;
            end
            if (state == S_CSUM) csum_q <= csum_c;
            if (step_pay) begin
                rem_q  <= last_in ? 16'd0 : rem_q - 16'd8;
                prev_q <= pay_masked[15:0];
                if (set_fill) fill_q <= 1'b1;
                if (set_late) late_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_builder.sv
// tb_udp_frame_builder: self-checking bench for udp_frame_builder (default
// build, ip_id from cfg_ip_id). Expected frames are built byte-by-byte from
// the configuration and payload, queued when a frame is driven, and compared
// word-by-word as the DUT hands them off.
module tb_udp_frame_builder;

    logic        clk, reset_n;
    logic [63:0] in_data;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic [15:0] payload_len;
    logic [47:0] cfg_dst_mac, cfg_src_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip;
    logic [15:0] cfg_src_port, cfg_dst_port, cfg_ip_id;
    logic [63:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop;
    logic [2:0]  out_empty;
    logic        err_len, err_eop;

    udp_frame_builder dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .payload_len(payload_len),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
        .cfg_ip_id(cfg_ip_id),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .err_len(err_len), .err_eop(err_eop)
    );

    typedef struct {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] act_q[$];
    int          vecs = 0, miscompares = 0;
    int          cyc = 0, sop_cyc = 0, ov_cnt = 0, ir_cnt = 0, el_cnt = 0, ee_cnt = 0;
    bit          sop_seen = 0, throttle = 0, stall_q = 0;
    logic [69:0] held;
    logic [2:0]  last_empty;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_q = 0;
        end else begin
            if (stall_q)
                check("hold", {out_valid, out_sop, out_eop, out_empty, out_data}, held);
            if (out_valid && out_sop && !sop_seen) begin
                sop_seen = 1;
                sop_cyc  = cyc;
            end
            if (out_valid) ov_cnt++;
            if (in_ready)  ir_cnt++;
            if (err_len)   el_cnt++;
            if (err_eop)   ee_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_word", 128'(sb.size()), 128'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word", {out_sop, out_eop, out_empty, out_data},
                          {e.sop, e.eop, e.empty, e.d});
                end
                act_q.push_back(out_data);
                if (out_eop) last_empty = out_empty;
            end
            stall_q = out_valid && !out_ready;
            held    = {out_valid, out_sop, out_eop, out_empty, out_data};
        end
    end

    // Builds the expected frame; payload bytes at or past vin are zero fill.
    task automatic push_expected(input int len, input int vin, input logic [63:0] wq[$]);
        logic [7:0]  b[$];
        logic [15:0] iplen, udplen;
        logic [31:0] sum;
        logic [63:0] w;
        int          pad;
        exp_t        e;
        iplen  = 16'(len + 28);
        udplen = 16'(len + 8);
        for (int i = 5; i >= 0; i--) b.push_back(cfg_dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(cfg_src_mac[8*i +: 8]);
        b.push_back(8'h08); b.push_back(8'h00); b.push_back(8'h45); b.push_back(8'h00);
        b.push_back(iplen[15:8]); b.push_back(iplen[7:0]);
        b.push_back(cfg_ip_id[15:8]); b.push_back(cfg_ip_id[7:0]);
        b.push_back(8'h40); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h11);
        b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(cfg_src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(cfg_dst_ip[8*i +: 8]);
        b.push_back(cfg_src_port[15:8]); b.push_back(cfg_src_port[7:0]);
        b.push_back(cfg_dst_port[15:8]); b.push_back(cfg_dst_port[7:0]);
        b.push_back(udplen[15:8]); b.push_back(udplen[7:0]);
        b.push_back(8'h00); b.push_back(8'h00);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'h0, b[i], b[i+1]};
        while (sum[31:16] != 0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        sum = ~sum;
        b[24] = sum[15:8];
        b[25] = sum[7:0];
        for (int i = 0; i < len; i++) begin
            if (i < vin) begin
                w = wq[i/8];
                b.push_back(w[63-8*(i%8) -: 8]);
            end else begin
                b.push_back(8'h00);
            end
        end
        pad = 0;
        while (b.size() % 8 != 0) begin
            b.push_back(8'h00);
            pad++;
        end
        for (int k = 0; k < b.size() / 8; k++) begin
            e.d = '0;
            for (int j = 0; j < 8; j++) e.d = {e.d[55:0], b[8*k+j]};
            e.sop   = (k == 0);
            e.eop   = (k == b.size() / 8 - 1);
            e.empty = e.eop ? 3'(pad) : 3'd0;
            sb.push_back(e);
        end
    endtask

    // Presents nwords random words (sop on the first, eop on eop_at) and waits
    // for each to be consumed.
    task automatic run_frame(input int len, input int nwords, input int eop_at, input bit expect_frame);
        logic [63:0] wq[$];
        bit          got;
        int          budget;
        for (int i = 0; i < nwords; i++) wq.push_back({$urandom, $urandom});
        if (expect_frame) push_expected(len, 8 * (eop_at + 1), wq);
        for (int i = 0; i < nwords; i++) begin
            in_data     = wq[i];
            in_valid    = 1;
            in_sop      = (i == 0);
            in_eop      = (i == eop_at);
            payload_len = 16'(len);
            got         = 0;
            budget      = 0;
            while (!got && budget < 500) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            check("in_handshake", 128'(got), 128'd1);
            if (!got) break;
        end
        in_valid = 0;
        in_sop   = 0;
        in_eop   = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4000 && sb.size() != 0; k++) @(posedge clk);
        check("drain", 128'(sb.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        act_q.delete();
        sop_seen = 0;
        ir_cnt   = 0;
        ov_cnt   = 0;
    endtask

    initial begin
        int          t0, el0, ee0;
        bit          got;
        logic [63:0] w3;

        reset_n = 0; in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0; payload_len = '0;
        cfg_dst_mac = 48'h0011_2233_4455; cfg_src_mac = 48'h0A0B_0C0D_0E0F;
        cfg_src_ip = 32'hC0A8_0001; cfg_dst_ip = 32'hC0A8_00C7;
        cfg_src_port = 16'h1234; cfg_dst_port = 16'h5678; cfg_ip_id = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {out_valid, out_sop, out_eop, out_empty, out_data, in_ready, err_len, err_eop}, '0);
        reset_n = 1;
        @(posedge clk);
        #1;

        // L=87: header constants, word count, empty, sop latency
        new_frame();
        t0 = cyc;
        run_frame(87, 11, 10, 1);
        drain();
        check("l87_w2", act_q[2], 64'h0073_0000_4000_4011);
        check("l87_csum", 128'(act_q[3][63:48]), 128'h B861);
        check("l87_words", 128'(act_q.size()), 128'd17);
        check("l87_empty", 128'(last_empty), 128'd7);
        check("sop_latency", 128'(sop_cyc - t0), 128'd2);

        // L=6: single payload word, no tail
        cfg_ip_id = 16'hBEEF; cfg_src_port = 16'h0400;
        new_frame();
        run_frame(6, 1, 0, 1);
        drain();
        check("l6_words", 128'(act_q.size()), 128'd6);
        check("l6_empty", 128'(last_empty), 128'd0);
        check("l6_in_ready", 128'(ir_cnt), 128'd1);

        // L=7 and L=16: tail word
        new_frame();
        run_frame(7, 1, 0, 1);
        drain();
        check("l7_words", 128'(act_q.size()), 128'd7);
        check("l7_empty", 128'(last_empty), 128'd7);
        new_frame();
        run_frame(16, 2, 1, 1);
        drain();
        check("l16_words", 128'(act_q.size()), 128'd8);
        check("l16_empty", 128'(last_empty), 128'd6);

        // L=100 with random output backpressure
        cfg_dst_mac = 48'hFFEE_DDCC_BBAA; cfg_dst_ip = 32'h0A00_0002; cfg_ip_id = 16'h7FFF;
        throttle = 1;
        new_frame();
        run_frame(100, 13, 12, 1);
        drain();
        throttle = 0;
        repeat (2) @(posedge clk);
        #1;
        check("l100_words", 128'(act_q.size()), 128'd18);

        // Illegal lengths: error pulse, input drained, nothing emitted
        new_frame();
        el0 = el_cnt;
        run_frame(0, 2, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("l0_err_len", 128'(el_cnt - el0), 128'd1);
        check("l0_no_out", 128'(ov_cnt), 128'd0);
        el0 = el_cnt;
        run_frame(1500, 3, 2, 0);
        repeat (4) @(posedge clk);
        #1;
        check("l1500_err_len", 128'(el_cnt - el0), 128'd1);
        el0 = el_cnt;
        run_frame(1473, 2, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("l1473_err_len", 128'(el_cnt - el0), 128'd1);
        check("bad_len_no_out", 128'(ov_cnt), 128'd0);
        new_frame();
        el0 = el_cnt;
        run_frame(1472, 184, 183, 1);
        drain();
        check("l1472_words", 128'(act_q.size()), 128'd190);
        check("l1472_no_err", 128'(el_cnt - el0), 128'd0);

        // Early eop: L=24, eop on the 2nd word, remainder zero-filled
        new_frame();
        ee0 = ee_cnt;
        run_frame(24, 2, 1, 1);
        drain();
        check("early_err_eop", 128'(ee_cnt - ee0), 128'd1);
        check("early_words", 128'(act_q.size()), 128'd9);

        // Late eop: L=10 but eop on the 3rd word, extra word dropped
        new_frame();
        ee0 = ee_cnt;
        run_frame(10, 3, 2, 1);
        drain();
        check("late_err_eop", 128'(ee_cnt - ee0), 128'd1);
        check("late_words", 128'(act_q.size()), 128'd7);
        new_frame();
        run_frame(20, 3, 2, 1);
        drain();
        check("after_late_words", 128'(act_q.size()), 128'd8);

        // Reset while W3 is on the output
        new_frame();
        begin
            logic [63:0] wq[$];
            wq.push_back({$urandom, $urandom});
            wq.push_back({$urandom, $urandom});
            wq.push_back({$urandom, $urandom});
            push_expected(24, 24, wq);
            w3 = sb[3].d;
            in_data = wq[0]; in_valid = 1; in_sop = 1; in_eop = 0; payload_len = 16'd24;
        end
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (out_valid && out_data === w3) got = 1;
        end
        check("reach_hdr3", 128'(got), 128'd1);
        @(posedge clk);
        #1;
        reset_n = 0; in_valid = 0; in_sop = 0;
        @(posedge clk);
        #1;
        check("mid_reset", {out_valid, out_sop, out_eop, out_empty, out_data, in_ready, err_len, err_eop}, '0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk);
        #1;
        new_frame();
        t0 = cyc;
        run_frame(30, 4, 3, 1);
        drain();
        check("post_reset_words", 128'(act_q.size()), 128'd9);
        check("post_reset_latency", 128'(sop_cyc - t0), 128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
